// File: rtl/exe_fwd_multi.sv
// exe_fwd_multi: multi-lane operand forwarding and load-use interlock between decode and execute.
// Latency: op/stall/iss_fire are combinational; EXE->MEM->WB slots advance one step per clk edge.
// Backpressure: stall and ext_stall block issue; ext_stall freezes all slots; flush kills EXE/MEM.
// Optional statistics counters are compiled in with `define FWD_STATS_EN.
module exe_fwd_multi #(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int TAGW  = 7
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       dec_valid,
  input  logic [LANES*2*TAGW-1:0]    dec_rs,
  input  logic [LANES*2*XLEN-1:0]    dec_op,
  input  logic [LANES*TAGW-1:0]      dec_rd,
  input  logic [LANES-1:0]           dec_isload,
  input  logic                       ext_stall,
  input  logic                       flush,
  input  logic [LANES*XLEN-1:0]      exe_result,
  input  logic [LANES*XLEN-1:0]      wb_memdata,
  output logic [LANES*2*XLEN-1:0]    op,
  output logic                       stall,
  output logic                       iss_fire
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]                stat_fwd,
  output logic [31:0]                stat_stall
`endif
);

  localparam int NOPS = 2 * LANES;

  // Per-slot destination bookkeeping; ALU results live alongside for MEM/WB.
  typedef struct packed {
    logic [LANES-1:0][TAGW-1:0] rd;
    logic [LANES-1:0]           ld;
    logic [LANES-1:0]           v;
  } slot_t;

  slot_t                      exe_s, mem_s, wb_s;
  logic [LANES-1:0][XLEN-1:0] mem_res, wb_res;

  logic [TAGW-1:0] src_tag;
  logic [XLEN-1:0] fwd_val;
  logic            fwd_haz;
  logic            haz_any;

  // A source matches a producer only for valid tags, identical tags, live slot, and never x0.
  function automatic logic tag_match(input logic [TAGW-1:0] s, input logic [TAGW-1:0] d,
                                     input logic v);
    return v & s[TAGW-1] & d[TAGW-1] & (s == d) & (s[TAGW-2:0] != '0);
  endfunction

  // Operand selection: scan oldest to youngest so the youngest (and highest lane) match wins.
  always_comb begin
    op      = dec_op;
    haz_any = 1'b0;
    src_tag = '0;
    fwd_val = '0;
    fwd_haz = 1'b0;
    for (int k = 0; k < NOPS; k++) begin
      src_tag = dec_rs[k*TAGW +: TAGW];
      fwd_val = dec_op[k*XLEN +: XLEN];
      fwd_haz = 1'b0;
      for (int l = 0; l < LANES; l++) begin
        if (tag_match(src_tag, wb_s.rd[l], wb_s.v[l])) begin
          fwd_haz = 1'b0;
          fwd_val = wb_s.ld[l] ? wb_memdata[l*XLEN +: XLEN] : wb_res[l];
        end
      end
      for (int l = 0; l < LANES; l++) begin
        if (tag_match(src_tag, mem_s.rd[l], mem_s.v[l])) begin
          fwd_haz = mem_s.ld[l];
          fwd_val = mem_res[l];
        end
      end
      for (int l = 0; l < LANES; l++) begin
        if (tag_match(src_tag, exe_s.rd[l], exe_s.v[l])) begin
          fwd_haz = exe_s.ld[l];
          fwd_val = exe_result[l*XLEN +: XLEN];
        end
      end
      op[k*XLEN +: XLEN] = fwd_val;
      haz_any            = haz_any | fwd_haz;
    end
  end

  assign stall    = dec_valid & haz_any;
  // Gated by rstn so nothing is reported as issued while the slots are held in reset.
  assign iss_fire = rstn & dec_valid & ~stall & ~ext_stall & ~flush;

  // Slot pipeline: flush kills EXE/MEM but lets MEM retire into WB; ext_stall freezes everything.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exe_s   <= '0;
      mem_s   <= '0;
      wb_s    <= '0;
      mem_res <= '0;
      wb_res  <= '0;
    end else if (flush) begin
      exe_s.v <= '0;
      mem_s.v <= '0;
      wb_s    <= mem_s;
      wb_res  <= mem_res;
    end else if (!ext_stall) begin
      exe_s.rd <= dec_rd;
      exe_s.ld <= dec_isload;
      exe_s.v  <= {LANES{iss_fire}};
      mem_s    <= exe_s;
      mem_res  <= exe_result;
      wb_s     <= mem_s;
      wb_res   <= mem_res;
    end
  end

`ifdef FWD_STATS_EN
  logic [7:0]  fwd_cnt;
  logic        fwd_hit;
  logic [32:0] fwd_sum;

  // Count operands that found any producer this cycle; only sampled when the bundle issues.
  always_comb begin
    fwd_cnt = '0;
    fwd_hit = 1'b0;
    for (int k = 0; k < NOPS; k++) begin
      fwd_hit = 1'b0;
      for (int l = 0; l < LANES; l++) begin
        fwd_hit = fwd_hit
                | tag_match(dec_rs[k*TAGW +: TAGW], exe_s.rd[l], exe_s.v[l])
                | tag_match(dec_rs[k*TAGW +: TAGW], mem_s.rd[l], mem_s.v[l])
                | tag_match(dec_rs[k*TAGW +: TAGW], wb_s.rd[l],  wb_s.v[l]);
      end
      fwd_cnt = fwd_cnt + {7'b0, fwd_hit};
    end
  end

  assign fwd_sum = {1'b0, stat_fwd} + {25'b0, fwd_cnt};

  // Saturating event counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_fwd   <= '0;
      stat_stall <= '0;
    end else begin
      if (iss_fire) begin
        stat_fwd <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
      end
      if (stall && (stat_stall != 32'hFFFF_FFFF)) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exe_fwd_multi.sv
// tb_exe_fwd_multi: directed and randomized checks of exe_fwd_multi against an in-bench model.
// Inputs change on the falling edge; outputs are compared 1 time unit later, before the rising edge.
// The model is a queue of issued bundles tagged with their age (1=EXE, 2=MEM, 3=WB).
module tb_exe_fwd_multi;
  localparam int LANES = 2;
  localparam int XLEN  = 32;
  localparam int TAGW  = 7;
  localparam int NOPS  = 2 * LANES;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    dec_valid;
  logic [LANES*2*TAGW-1:0] dec_rs;
  logic [LANES*2*XLEN-1:0] dec_op;
  logic [LANES*TAGW-1:0]   dec_rd;
  logic [LANES-1:0]        dec_isload;
  logic                    ext_stall;
  logic                    flush;
  logic [LANES*XLEN-1:0]   exe_result;
  logic [LANES*XLEN-1:0]   wb_memdata;
  logic [LANES*2*XLEN-1:0] op;
  logic                    stall;
  logic                    iss_fire;
`ifdef FWD_STATS_EN
  logic [31:0]             stat_fwd;
  logic [31:0]             stat_stall;
  logic [31:0]             m_fwd;
  logic [31:0]             m_stall;
`endif

  always #5 clk = ~clk;

  exe_fwd_multi #(.LANES(LANES), .XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .dec_valid  (dec_valid),
    .dec_rs     (dec_rs),
    .dec_op     (dec_op),
    .dec_rd     (dec_rd),
    .dec_isload (dec_isload),
    .ext_stall  (ext_stall),
    .flush      (flush),
    .exe_result (exe_result),
    .wb_memdata (wb_memdata),
    .op         (op),
    .stall      (stall),
    .iss_fire   (iss_fire)
`ifdef FWD_STATS_EN
    ,
    .stat_fwd   (stat_fwd),
    .stat_stall (stat_stall)
`endif
  );

  typedef struct {
    logic [LANES-1:0][TAGW-1:0] rd;
    logic [LANES-1:0]           ld;
    logic [LANES-1:0][XLEN-1:0] res;
    int                         age;
  } ent_t;

  ent_t pipe[$];  // youngest first

  int            n_vec = 0;
  int            n_err = 0;
  logic          exp_stall;
  logic          exp_iss;
  logic [XLEN-1:0] exp_op [NOPS];
  logic          exp_dc [NOPS];
  int            exp_hits;

  function automatic logic [TAGW-1:0] xr(input int n);
    return {2'b10, 5'(n)};
  endfunction

  function automatic logic [TAGW-1:0] fr(input int n);
    return {2'b11, 5'(n)};
  endfunction

  function automatic logic [TAGW-1:0] rtag();
    return {($urandom_range(0, 7) != 0), 1'($urandom), 3'b000, 2'($urandom)};
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Youngest producer per operand, straight from the ordering rules.
  task automatic model_eval();
    logic [TAGW-1:0] src;
    logic            hit;
    logic            any_dc;
    any_dc   = 1'b0;
    exp_hits = 0;
    for (int k = 0; k < NOPS; k++) begin
      src       = dec_rs[k*TAGW +: TAGW];
      hit       = 1'b0;
      exp_dc[k] = 1'b0;
      exp_op[k] = dec_op[k*XLEN +: XLEN];
      if (src[TAGW-1] && src[TAGW-2:0] != '0) begin
        for (int i = 0; i < pipe.size(); i++) begin
          for (int l = LANES - 1; l >= 0; l--) begin
            if (!hit && pipe[i].rd[l] == src) begin
              hit = 1'b1;
              if (pipe[i].age == 1) begin
                if (pipe[i].ld[l]) exp_dc[k] = 1'b1;
                else exp_op[k] = exe_result[l*XLEN +: XLEN];
              end else if (pipe[i].age == 2) begin
                if (pipe[i].ld[l]) exp_dc[k] = 1'b1;
                else exp_op[k] = pipe[i].res[l];
              end else begin
                exp_op[k] = pipe[i].ld[l] ? wb_memdata[l*XLEN +: XLEN] : pipe[i].res[l];
              end
            end
          end
        end
      end
      if (exp_dc[k]) any_dc = 1'b1;
      else if (hit) exp_hits++;
    end
    exp_stall = dec_valid & any_dc;
    exp_iss   = rstn & dec_valid & ~exp_stall & ~ext_stall & ~flush;
  endtask

  task automatic model_step();
    ent_t q2[$];
    ent_t e;
`ifdef FWD_STATS_EN
    logic [32:0] s;
    if (exp_iss) begin
      s     = {1'b0, m_fwd} + 33'(exp_hits);
      m_fwd = s[32] ? 32'hFFFF_FFFF : s[31:0];
    end
    if (exp_stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
    if (flush) begin
      foreach (pipe[i]) if (pipe[i].age == 2) begin
        e = pipe[i]; e.age = 3; q2.push_back(e);
      end
      pipe = q2;
    end else if (!ext_stall) begin
      foreach (pipe[i]) begin
        e = pipe[i];
        if (e.age == 1) e.res = exe_result;
        e.age++;
        if (e.age <= 3) q2.push_back(e);
      end
      if (exp_iss) begin
        e.rd  = dec_rd;
        e.ld  = dec_isload;
        e.res = '0;
        e.age = 1;
        q2.push_front(e);
      end
      pipe = q2;
    end
  endtask

  task automatic check_now();
    #1;
    if (!rstn) begin
      pipe.delete();
`ifdef FWD_STATS_EN
      m_fwd   = '0;
      m_stall = '0;
`endif
    end
    model_eval();
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("iss_fire", 32'(iss_fire), 32'(exp_iss));
    for (int k = 0; k < NOPS; k++)
      if (!exp_dc[k]) chk($sformatf("op%0d", k), op[k*XLEN +: XLEN], exp_op[k]);
`ifdef FWD_STATS_EN
    chk("stat_fwd", stat_fwd, m_fwd);
    chk("stat_stall", stat_stall, m_stall);
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    if (rstn) model_step();
    @(negedge clk);
  endtask

  task automatic clear();
    dec_valid  = 1'b0;
    dec_rs     = '0;
    dec_op     = '0;
    dec_rd     = '0;
    dec_isload = '0;
    ext_stall  = 1'b0;
    flush      = 1'b0;
    exe_result = '0;
    wb_memdata = '0;
  endtask

  task automatic drain();
    repeat (3) begin
      clear(); check_now(); advance();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear();
    rstn = 1'b0;
`ifdef FWD_STATS_EN
    m_fwd   = '0;
    m_stall = '0;
`endif
    @(negedge clk);
    dec_op = {32'h4, 32'h3, 32'h2, 32'h1};
    check_now();
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_iss", 32'(iss_fire), 32'h0);
    chk("rst_op2", op[2*XLEN +: XLEN], 32'h3);
    advance();
    rstn = 1'b1;
    drain();

    // Back-to-back ALU
    clear(); dec_valid = 1'b1; dec_rd[0 +: TAGW] = xr(5);
    check_now(); chk("b2b_iss0", 32'(iss_fire), 32'h1); advance();
    clear(); dec_valid = 1'b1; dec_rs[2*TAGW +: TAGW] = xr(5); exe_result[0 +: XLEN] = 32'h11;
    check_now();
    chk("b2b_op", op[2*XLEN +: XLEN], 32'h11);
    chk("b2b_stall", 32'(stall), 32'h0);
    chk("b2b_iss", 32'(iss_fire), 32'h1);
    advance();
    drain();

    // Load-use
    clear(); dec_valid = 1'b1; dec_rd[0 +: TAGW] = xr(7); dec_isload = 2'b01;
    check_now(); advance();
    clear(); dec_valid = 1'b1; dec_rs[0 +: TAGW] = xr(7);
    check_now(); chk("lu_stall1", 32'(stall), 32'h1); chk("lu_iss1", 32'(iss_fire), 32'h0);
    advance();
    check_now(); chk("lu_stall2", 32'(stall), 32'h1); advance();
    wb_memdata[0 +: XLEN] = 32'hCAFE;
    check_now();
    chk("lu_op", op[0 +: XLEN], 32'hCAFE);
    chk("lu_stall3", 32'(stall), 32'h0);
    chk("lu_iss", 32'(iss_fire), 32'h1);
    advance();
    drain();

    // Priority and x0
    clear(); dec_valid = 1'b1; dec_rd[0 +: TAGW] = xr(3);
    check_now(); advance();
    clear(); dec_valid = 1'b1; dec_rd = {xr(3), xr(3)}; exe_result[0 +: XLEN] = 32'd1;
    check_now(); advance();
    clear(); dec_valid = 1'b1; dec_rs[1*TAGW +: TAGW] = xr(3); exe_result = {32'd3, 32'd2};
    check_now(); chk("prio_op", op[1*XLEN +: XLEN], 32'd3); advance();
    clear(); dec_valid = 1'b1; dec_rd[0 +: TAGW] = xr(0);
    check_now(); advance();
    clear(); dec_valid = 1'b1; dec_rs[0 +: TAGW] = xr(0); dec_op[0 +: XLEN] = 32'h55;
    check_now(); chk("x0_op", op[0 +: XLEN], 32'h55); advance();
    drain();

    // Int/float separation
    clear(); dec_valid = 1'b1; dec_rd[0 +: TAGW] = fr(4);
    check_now(); advance();
    clear(); exe_result[0 +: XLEN] = 32'h40490FDB;
    check_now(); advance();
    clear(); dec_valid = 1'b1; dec_rs[0 +: TAGW] = xr(4); dec_rs[TAGW +: TAGW] = fr(4);
    dec_op[0 +: XLEN] = 32'd9;
    check_now();
    chk("int_op", op[0 +: XLEN], 32'd9);
    chk("flt_op", op[XLEN +: XLEN], 32'h40490FDB);
    advance();
    drain();

    // Flush clears a pending load-use; ext_stall holds slots
    clear(); dec_valid = 1'b1; dec_rd[0 +: TAGW] = xr(9); dec_isload = 2'b01;
    check_now(); advance();
    clear(); dec_valid = 1'b1; dec_rs[0 +: TAGW] = xr(9); dec_op[0 +: XLEN] = 32'h77; flush = 1'b1;
    check_now(); chk("fl_stall1", 32'(stall), 32'h1); advance();
    flush = 1'b0;
    check_now();
    chk("fl_stall2", 32'(stall), 32'h0);
    chk("fl_op", op[0 +: XLEN], 32'h77);
    advance();
    drain();
    clear(); dec_valid = 1'b1; dec_rd[0 +: TAGW] = xr(10);
    check_now(); advance();
    clear(); dec_valid = 1'b1; dec_rs[0 +: TAGW] = xr(10); exe_result[0 +: XLEN] = 32'hAB;
    ext_stall = 1'b1;
    check_now(); chk("es_op1", op[0 +: XLEN], 32'hAB); chk("es_iss", 32'(iss_fire), 32'h0);
    advance();
    check_now(); chk("es_op2", op[0 +: XLEN], 32'hAB); advance();
    drain();

    // Reset with a load in MEM
    clear(); dec_valid = 1'b1; dec_rd[0 +: TAGW] = xr(12); dec_isload = 2'b01;
    check_now(); advance();
    clear(); check_now(); advance();
    rstn = 1'b0;
    check_now();
`ifdef FWD_STATS_EN
    chk("rst_stat_fwd", stat_fwd, 32'h0);
    chk("rst_stat_stall", stat_stall, 32'h0);
`endif
    advance();
    rstn = 1'b1;
    clear(); dec_valid = 1'b1; dec_rs[0 +: TAGW] = xr(12); dec_op[0 +: XLEN] = 32'h33;
    check_now();
    chk("rst_fwd_op", op[0 +: XLEN], 32'h33);
    chk("rst_fwd_stall", 32'(stall), 32'h0);
    advance();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rstn       = ($urandom_range(0, 199) != 0);
      dec_valid  = ($urandom_range(0, 4) != 0);
      for (int k = 0; k < NOPS; k++) begin
        dec_rs[k*TAGW +: TAGW] = rtag();
        dec_op[k*XLEN +: XLEN] = $urandom;
      end
      for (int l = 0; l < LANES; l++) begin
        dec_rd[l*TAGW +: TAGW]     = rtag();
        dec_isload[l]              = ($urandom_range(0, 9) < 3);
        exe_result[l*XLEN +: XLEN] = $urandom;
        wb_memdata[l*XLEN +: XLEN] = $urandom;
      end
      flush     = ($urandom_range(0, 19) == 0);
      ext_stall = !flush && ($urandom_range(0, 99) < 15);
      check_now();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exe_fwd_multi.md
Name: exe_fwd_multi

Overview:
- Multi-lane operand forwarding and load-use interlock unit for the VLIW core; sits between decode and execute.
- Tracks in-flight destinations of issued bundles through EXE/MEM/WB slots.
- Substitutes the youngest matching result into each decoded operand.
- Raises a stall when an operand's youngest producer is a load whose data is not yet back.

Parameters:
- LANES, 2, issue lanes per bundle (lane index = program order within bundle)
- XLEN, 32, operand/result width
- TAGW, 7, register tag {valid, fromfreg, regnum[TAGW-3:0]}

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- dec_valid  in  1  decoded bundle present
- dec_rs  in  LANES*2*TAGW  source tags, {lane}{rs2,rs1}
- dec_op  in  LANES*2*XLEN  register-file operand values, same packing
- dec_rd  in  LANES*TAGW  destination tags of decoded bundle
- dec_isload  in  LANES  lane is a load
- ext_stall  in  1  downstream freeze
- flush  in  1  kill EXE and MEM slots (mispredict)
- exe_result  in  LANES*XLEN  ALU results of bundle in EXE slot (same cycle)
- wb_memdata  in  LANES*XLEN  load data of bundle in WB slot
- op  out  LANES*2*XLEN  forwarded operands
- stall  out  1  load-use interlock
- iss_fire  out  1  bundle accepted into EXE

Behaviour:
- Reset is asynchronous on rstn low. All slot valid bits clear. stall=0, iss_fire=0. op equals dec_op.
- Tag match requires all of:
  - tag[TAGW-1]=1 on both source and destination;
  - full-tag equality;
  - slot valid.
- Integer x0 (fromfreg=0, regnum=0) never matches. f0 does match.
- Slots: EXE, MEM, WB. Each holds per lane: rd tag, isload, valid. MEM and WB also hold a registered ALU result.
- On each clk edge with ext_stall=0:
  - EXE<=decoded bundle if iss_fire, else a bubble (valid=0).
  - MEM<=EXE, capturing exe_result.
  - WB<=MEM.
- With ext_stall=1, all slots hold.
- flush=1 (takes priority over ext_stall): EXE and MEM valids clear at the next edge. WB advances normally.
- Forward source priority, youngest first: EXE > MEM > WB. Within a slot, the higher lane index wins.
- Value selection for the first matching producer:
  - EXE non-load: exe_result[lane], combinational.
  - MEM non-load: registered result.
  - WB non-load: registered result.
  - WB load: wb_memdata[lane].
  - No match: dec_op.
- Load-use: if the first matching producer is a load in EXE or MEM, stall=1 (only when dec_valid=1). op for that operand is don't-care.
- An older match is never used when a younger load matches.
- stall is purely combinational from the current slot contents and dec_rs. No latency.
- iss_fire = dec_valid & ~stall & ~ext_stall & ~flush.
- Operands within one bundle are not checked against each other; the compiler guarantees lane independence.
- Latency: an ALU producer at issue cycle T is forwardable at T+1 (EXE), T+2 (MEM) and T+3 (WB). A load producer is forwardable only at T+3.
- Reset mid-operation discards all slots; no stale forward may occur after rstn rises.

Optional Feature:
- FWD_STATS_EN defined: adds outputs stat_fwd (32) and stat_stall (32).
  - stat_fwd: saturating count of operands forwarded from any slot in iss_fire cycles.
  - stat_stall: saturating count of cycles with stall=1.
  - Both are reset to 0 by rstn and hold at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent. Forwarding/stall behaviour is identical.

Test Plan:
- Back-to-back ALU: lane0 writes x5 with exe_result=32'h11. Next bundle lane1 reads x5 with dec_op=0 -> op=32'h11, stall=0, iss_fire=1.
- Load-use: load to x7 issued. Next cycle lane0 reads x7 -> stall=1 for 2 cycles. Then wb_memdata=32'hCAFE forwarded, iss_fire=1.
- Priority: x3 written by MEM lane0 (=1), EXE lane0 (=2), EXE lane1 (=3) -> op=3. With x0 as destination, a read of x0 returns dec_op.
- Int/float separation: MEM writes f4=32'h40490FDB. Read x4 with dec_op=9 -> op=9. Read f4 -> op=32'h40490FDB.
- flush with a load in EXE and a dependent read stalled -> next cycle stall=0, op=dec_op. ext_stall=1 holds slots and forward values unchanged.
- Reset: rstn low while a load is in MEM -> after release, a read of the same tag returns dec_op, stall=0. With FWD_STATS_EN, counters read 0.
